// File: rtl/rv64g_l2_pkg.sv
// ----------------------------------------------------------------------------
// rv64g_l2_pkg
// Shared types for the L2 directory update controller:
//   - dir_op_t    : coherence request opcodes
//   - dir_state_t : controller FSM states
//   - dir_entry_t : one directory way {valid, sharers, owner_valid, owner_id, dirty}
// DIR_CORES sizes the entry struct; the controller's CORES parameter must
// match it.
// ----------------------------------------------------------------------------
package rv64g_l2_pkg;

    localparam int DIR_CORES  = 4;
    localparam int DIR_CORE_W = $clog2(DIR_CORES);

    typedef enum logic [1:0] {
        OP_ACQ_S     = 2'd0,
        OP_ACQ_U     = 2'd1,
        OP_REL_CLEAN = 2'd2,
        OP_REL_DIRTY = 2'd3
    } dir_op_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ       = 3'd1,
        ST_PROBE_REQ  = 3'd2,
        ST_PROBE_WAIT = 3'd3,
        ST_WRITE      = 3'd4,
        ST_RESP       = 3'd5
    } dir_state_t;

    typedef struct packed {
        logic                  valid;
        logic [DIR_CORES-1:0]  sharers;
        logic                  owner_valid;
        logic [DIR_CORE_W-1:0] owner_id;
        logic                  dirty;
    } dir_entry_t;

    function automatic logic [DIR_CORES-1:0] core_onehot(input logic [DIR_CORE_W-1:0] id);
        return DIR_CORES'(1) << id;
    endfunction

endpackage

// File: rtl/rv64g_l2_dir_next_state.sv
// ----------------------------------------------------------------------------
// rv64g_l2_dir_next_state
// Purely combinational next-entry calculation for one directory way.
// Ports:
//   cur_entry  : entry as read from the directory
//   op, core   : request opcode and requesting core
//   nxt_entry  : entry to write back
//   probe_mask : cores that must be probed before the write
//   resp_dirty : old entry was dirty and ownership is being taken away
//   resp_wb    : REL_DIRTY from the owner, data array must write the line
//   resp_err   : REL_DIRTY from a non-owner, no write is to be issued
// ----------------------------------------------------------------------------
module rv64g_l2_dir_next_state
    import rv64g_l2_pkg::*;
(
    input  dir_entry_t             cur_entry,
    input  dir_op_t                op,
    input  logic [DIR_CORE_W-1:0]  core,
    output dir_entry_t             nxt_entry,
    output logic [DIR_CORES-1:0]   probe_mask,
    output logic                   resp_dirty,
    output logic                   resp_wb,
    output logic                   resp_err
);

    dir_entry_t           eff;
    logic [DIR_CORES-1:0] c_mask;
    logic [DIR_CORES-1:0] o_mask;
    logic                 owner_is_core;

    always_comb begin
        // Stale fields of an invalid way must not generate probes or flags,
        // so an invalid entry is treated as all-zero.
        eff           = cur_entry.valid ? cur_entry : '0;
        c_mask        = core_onehot(core);
        o_mask        = eff.owner_valid ? core_onehot(eff.owner_id) : '0;
        owner_is_core = eff.owner_valid && (eff.owner_id == core);

        nxt_entry  = eff;
        probe_mask = '0;
        resp_dirty = 1'b0;
        resp_wb    = 1'b0;
        resp_err   = 1'b0;

        case (op)
            OP_ACQ_S: begin
                nxt_entry.valid = 1'b1;
                if (!cur_entry.valid) begin
                    nxt_entry.sharers = c_mask;
                end else if (eff.owner_valid && !owner_is_core) begin
                    // Downgrade the foreign owner to a sharer.
                    probe_mask            = o_mask;
                    nxt_entry.sharers     = c_mask | o_mask;
                    nxt_entry.owner_valid = 1'b0;
                    nxt_entry.dirty       = 1'b0;
                    resp_dirty            = eff.dirty;
                end else if (!eff.owner_valid) begin
                    nxt_entry.sharers = eff.sharers | c_mask;
                end
                // The owner re-acquiring shared already holds a superset
                // permission; the entry stays as is so that owner still
                // implies an empty sharer set.
            end
            OP_ACQ_U: begin
                probe_mask            = (eff.sharers | o_mask) & ~c_mask;
                nxt_entry.valid       = 1'b1;
                nxt_entry.owner_valid = 1'b1;
                nxt_entry.owner_id    = core;
                nxt_entry.sharers     = '0;
                nxt_entry.dirty       = 1'b0;
                resp_dirty            = eff.dirty;
            end
            OP_REL_CLEAN: begin
                nxt_entry.sharers = eff.sharers & ~c_mask;
                if (owner_is_core) begin
                    nxt_entry.owner_valid = 1'b0;
                    nxt_entry.dirty       = 1'b0;
                end
            end
            OP_REL_DIRTY: begin
                if (owner_is_core) begin
                    nxt_entry.owner_valid = 1'b0;
                    nxt_entry.sharers     = '0;
                    nxt_entry.dirty       = 1'b0;
                    resp_wb               = 1'b1;
                end else begin
                    resp_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv64g_l2_dir_update.sv
// ----------------------------------------------------------------------------
// rv64g_l2_dir_update
// Directory update controller: accepts one coherence request, reads the
// addressed directory set, probes other cores when needed, writes the new
// entry back and answers the L2 request pipeline.
// Ports:
//   req_*          : request handshake (op/set/way/core)
//   dir_rd_*       : combinational directory read of set dir_rd_set_o
//   dir_we_o/dir_wr_* : one-cycle directory write
//   probe_*        : probe request handshake and per-core ack pulses
//   resp_*         : response handshake with dirty/wb/err flags
// Optional: define RV64G_L2_DIR_UPD_PERF_EN to add saturating 32-bit
// counters perf_req_o, perf_probe_o, perf_err_o.
// ----------------------------------------------------------------------------
module rv64g_l2_dir_update
    import rv64g_l2_pkg::*;
#(
    parameter int SETS  = 256,
    parameter int WAYS  = 16,
    parameter int CORES = DIR_CORES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [1:0]                      req_op_i,
    input  logic [$clog2(SETS)-1:0]         req_set_i,
    input  logic [$clog2(WAYS)-1:0]         req_way_i,
    input  logic [$clog2(CORES)-1:0]        req_core_i,
    output logic [$clog2(SETS)-1:0]         dir_rd_set_o,
    input  logic [WAYS-1:0]                 dir_rd_valid_i,
    input  logic [WAYS*CORES-1:0]           dir_rd_sharers_i,
    input  logic [WAYS-1:0]                 dir_rd_owner_valid_i,
    input  logic [WAYS*$clog2(CORES)-1:0]   dir_rd_owner_id_i,
    input  logic [WAYS-1:0]                 dir_rd_dirty_i,
    output logic                            dir_we_o,
    output logic [$clog2(SETS)-1:0]         dir_wr_set_o,
    output logic [$clog2(WAYS)-1:0]         dir_wr_way_o,
    output logic                            dir_wr_valid_o,
    output logic [CORES-1:0]                dir_wr_sharers_o,
    output logic                            dir_wr_owner_valid_o,
    output logic [$clog2(CORES)-1:0]        dir_wr_owner_id_o,
    output logic                            dir_wr_dirty_o,
    output logic                            probe_valid_o,
    input  logic                            probe_ready_i,
    output logic [CORES-1:0]                probe_mask_o,
    input  logic [CORES-1:0]                probe_ack_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic                            resp_dirty_o,
    output logic                            resp_wb_o,
    output logic                            resp_err_o
`ifdef RV64G_L2_DIR_UPD_PERF_EN
    ,
    output logic [31:0]                     perf_req_o,
    output logic [31:0]                     perf_probe_o,
    output logic [31:0]                     perf_err_o
`endif
);

    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int CW    = $clog2(CORES);

    dir_state_t        state_reg, state_next;
    dir_op_t           op_reg;
    logic [SET_W-1:0]  set_reg;
    logic [WAY_W-1:0]  way_reg;
    logic [CW-1:0]     core_reg;
    dir_entry_t        wr_entry_reg;
    logic [CORES-1:0]  mask_reg;
    logic [CORES-1:0]  pending_reg;
    logic              resp_dirty_reg;
    logic              resp_wb_reg;
    logic              resp_err_reg;

    // Unpack the flat per-way read buses so the latched way can index them.
    logic [CORES-1:0]  rd_sharers  [WAYS];
    logic [CW-1:0]     rd_owner_id [WAYS];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_rd_unpack
            assign rd_sharers[gi]  = dir_rd_sharers_i[gi*CORES +: CORES];
            assign rd_owner_id[gi] = dir_rd_owner_id_i[gi*CW +: CW];
        end
    endgenerate

    dir_entry_t        rd_entry;
    dir_entry_t        ns_entry;
    logic [CORES-1:0]  ns_probe;
    logic              ns_dirty;
    logic              ns_wb;
    logic              ns_err;

    always_comb begin
        rd_entry.valid       = dir_rd_valid_i[way_reg];
        rd_entry.sharers     = rd_sharers[way_reg];
        rd_entry.owner_valid = dir_rd_owner_valid_i[way_reg];
        rd_entry.owner_id    = rd_owner_id[way_reg];
        rd_entry.dirty       = dir_rd_dirty_i[way_reg];
    end

    rv64g_l2_dir_next_state u_next_state (
        .cur_entry  (rd_entry),
        .op         (op_reg),
        .core       (core_reg),
        .nxt_entry  (ns_entry),
        .probe_mask (ns_probe),
        .resp_dirty (ns_dirty),
        .resp_wb    (ns_wb),
        .resp_err   (ns_err)
    );

    logic req_fire;
    logic probe_fire;
    logic resp_fire;

    assign req_fire   = (state_reg == ST_IDLE) && req_valid_i;
    assign probe_fire = (state_reg == ST_PROBE_REQ) && probe_ready_i;
    assign resp_fire  = (state_reg == ST_RESP) && resp_ready_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid_i) state_next = ST_READ;
            end
            ST_READ: begin
                if (ns_err)              state_next = ST_RESP;
                else if (ns_probe != '0) state_next = ST_PROBE_REQ;
                else                     state_next = ST_WRITE;
            end
            ST_PROBE_REQ: begin
                if (probe_ready_i) state_next = ST_PROBE_WAIT;
            end
            ST_PROBE_WAIT: begin
                // Leave as soon as the acks of this cycle clear the last bit.
                if ((pending_reg & ~probe_ack_i) == '0) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request context, computed entry, probe tracking, response flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg         <= OP_ACQ_S;
            set_reg        <= '0;
            way_reg        <= '0;
            core_reg       <= '0;
            wr_entry_reg   <= '0;
            mask_reg       <= '0;
            pending_reg    <= '0;
            resp_dirty_reg <= 1'b0;
            resp_wb_reg    <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_reg   <= dir_op_t'(req_op_i);
                        set_reg  <= req_set_i;
                        way_reg  <= req_way_i;
                        core_reg <= req_core_i;
                    end
                end
                ST_READ: begin
                    wr_entry_reg   <= ns_entry;
                    mask_reg       <= ns_probe;
                    resp_dirty_reg <= ns_dirty;
                    resp_wb_reg    <= ns_wb;
                    resp_err_reg   <= ns_err;
                end
                ST_PROBE_REQ: begin
                    // Acks seen before the probe is accepted are not counted.
                    if (probe_ready_i) pending_reg <= mask_reg;
                end
                ST_PROBE_WAIT: begin
                    pending_reg <= pending_reg & ~probe_ack_i;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_dirty_reg <= 1'b0;
                        resp_wb_reg    <= 1'b0;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready_o          = (state_reg == ST_IDLE);
    assign dir_rd_set_o         = (state_reg == ST_IDLE) ? '0 : set_reg;

    assign dir_we_o             = (state_reg == ST_WRITE);
    assign dir_wr_set_o         = set_reg;
    assign dir_wr_way_o         = way_reg;
    assign dir_wr_valid_o       = wr_entry_reg.valid;
    assign dir_wr_sharers_o     = wr_entry_reg.sharers;
    assign dir_wr_owner_valid_o = wr_entry_reg.owner_valid;
    assign dir_wr_owner_id_o    = wr_entry_reg.owner_id;
    assign dir_wr_dirty_o       = wr_entry_reg.dirty;

    assign probe_valid_o        = (state_reg == ST_PROBE_REQ);
    assign probe_mask_o         = (state_reg == ST_PROBE_REQ) ? mask_reg : '0;

    assign resp_valid_o         = (state_reg == ST_RESP);
    assign resp_dirty_o         = resp_valid_o & resp_dirty_reg;
    assign resp_wb_o            = resp_valid_o & resp_wb_reg;
    assign resp_err_o           = resp_valid_o & resp_err_reg;

`ifdef RV64G_L2_DIR_UPD_PERF_EN
    logic [31:0] perf_req_reg;
    logic [31:0] perf_probe_reg;
    logic [31:0] perf_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_req_reg   <= '0;
            perf_probe_reg <= '0;
            perf_err_reg   <= '0;
        end else begin
            if (req_fire && (perf_req_reg != '1))
                perf_req_reg <= perf_req_reg + 32'd1;
            if (probe_fire && (perf_probe_reg != '1))
                perf_probe_reg <= perf_probe_reg + 32'd1;
            if (resp_fire && resp_err_reg && (perf_err_reg != '1))
                perf_err_reg <= perf_err_reg + 32'd1;
        end
    end

    assign perf_req_o   = perf_req_reg;
    assign perf_probe_o = perf_probe_reg;
    assign perf_err_o   = perf_err_reg;
`else
    // Handshake strobes only feed the counters.
    logic unused_fire;
    assign unused_fire = req_fire ^ probe_fire ^ resp_fire;
`endif

endmodule
